alu_multicycle: RTL and testbench

//   Parametrised next-generation LEGv8 ALU: registered, handshaked execute unit.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_multicycle_if.sv | 27 ++
 rtl/muldiv_unit.sv | 52 +++++
 rtl/alu_multicycle.sv | 171 +++++++++++++++++
 tb/tb_alu_multicycle.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle LEGv8 ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'h0,
    OP_OR    = 4'h1,
    OP_ADD   = 4'h2,
    OP_SUB   = 4'h6,
    OP_PASSB = 4'h7,
    OP_MUL   = 4'h8,
    OP_UDIV  = 4'h9,
    OP_UREM  = 4'hA
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } alu_state_t;

  // Replicated to the operand width to form the divide-by-zero quotient.
  localparam bit DivZeroFill = 1'b1;

endpackage

// File: rtl/alu_multicycle_if.sv
// Request/response bundle between the EX-stage control and the ALU.
interface alu_multicycle_if #(
  parameter int unsigned N = 64
);
  logic         start;
  logic [3:0]   aluControl;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done;
  logic [N-1:0] result;
  logic         zero;
  logic         negative;
  logic         carry;
  logic         overflow;
  logic         divzero;

  modport master (
    output start, aluControl, a, b,
    input  ready, done, result, zero, negative, carry, overflow, divzero
  );

  modport slave (
    input  start, aluControl, a, b,
    output ready, done, result, zero, negative, carry, overflow, divzero
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider, one step per load or enable.
module muldiv_unit #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic         div,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] acc_next,
  output logic [N-1:0] q_next
);

  logic [N-1:0] acc_q, sh_q, q_q;
  logic [N-1:0] acc_c, sh_c, q_c, sh_next;
  logic [N:0]   partial;
  logic         fits;

  // The load cycle already performs the first step, so the parent sees the
  // final value on acc_next/q_next during the N-th step.
  always_comb begin
    acc_c   = load ? '0 : acc_q;
    sh_c    = load ? (div ? b : a) : sh_q;
    q_c     = load ? (div ? a : b) : q_q;
    partial = {acc_c, q_c[N-1]};
    fits    = partial >= {1'b0, sh_c};
    if (div) begin
      acc_next = fits ? (partial - {1'b0, sh_c}) : partial[N-1:0];
      q_next   = {q_c[N-2:0], fits};
      sh_next  = sh_c;
    end else begin
      acc_next = acc_c + (q_c[0] ? sh_c : '0);
      q_next   = q_c >> 1;
      sh_next  = sh_c << 1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      sh_q  <= '0;
      q_q   <= '0;
    end else if (load || en) begin
      acc_q <= acc_next;
      sh_q  <= sh_next;
      q_q   <= q_next;
    end
  end

endmodule

// File: rtl/alu_multicycle.sv
// Registered, handshaked EX-stage ALU: single-cycle logic/add ops plus iterative MUL/UDIV/UREM.
module alu_multicycle
  import alu_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input logic             clk,
  input logic             reset,
  alu_multicycle_if.slave bus
);

  localparam int unsigned CntW = $clog2(N);

  alu_state_t    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  alu_op_t       op_q;
  logic [N-1:0]  result_q, result_d;
  logic          zero_q, negative_q, carry_q, overflow_q, divzero_q;
  logic          carry_d, overflow_d, divzero_d;

  logic          accept, is_md_in, is_div_in, md_go;
  logic          cap_sc, cap_md, md_load, md_en, md_div;
  logic [N:0]    sum, diff;
  logic [N-1:0]  sc_res, acc_next, q_next;
  logic          sc_c, sc_v, sc_dz;

  assign accept    = bus.start && (state_q != RUN);
  assign is_div_in = (bus.aluControl == OP_UDIV) || (bus.aluControl == OP_UREM);
  assign is_md_in  = is_div_in || (bus.aluControl == OP_MUL);
  assign md_go     = is_md_in && !(is_div_in && (bus.b == '0));
  assign md_div    = md_load ? is_div_in : (op_q != OP_MUL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_sc  = 1'b0;
    cap_md  = 1'b0;
    md_load = 1'b0;
    md_en   = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          if (md_go) begin
            state_d = RUN;
            md_load = 1'b1;
            cnt_d   = CntW'(N - 2);
          end else begin
            state_d = DONE;
            cap_sc  = 1'b1;
          end
        end
      end
      RUN: begin
        md_en = 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
          cap_md  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single-cycle results; divides only land here when the divisor is zero.
  always_comb begin
    sum    = {1'b0, bus.a} + {1'b0, bus.b};
    diff   = {1'b0, bus.a} - {1'b0, bus.b};
    sc_res = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    sc_dz  = 1'b0;
    case (bus.aluControl)
      OP_AND:   sc_res = bus.a & bus.b;
      OP_OR:    sc_res = bus.a | bus.b;
      OP_ADD: begin
        sc_res = sum[N-1:0];
        sc_c   = sum[N];
        sc_v   = (bus.a[N-1] == bus.b[N-1]) && (sum[N-1] != bus.a[N-1]);
      end
      OP_SUB: begin
        sc_res = diff[N-1:0];
        sc_c   = ~diff[N];
        sc_v   = (bus.a[N-1] != bus.b[N-1]) && (diff[N-1] != bus.a[N-1]);
      end
      OP_PASSB: sc_res = bus.b;
      OP_UDIV: begin
        sc_res = {N{DivZeroFill}};
        sc_dz  = 1'b1;
      end
      OP_UREM: begin
        sc_res = bus.a;
        sc_dz  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    result_d   = result_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    divzero_d  = divzero_q;
    if (cap_sc) begin
      result_d   = sc_res;
      carry_d    = sc_c;
      overflow_d = sc_v;
      divzero_d  = sc_dz;
    end else if (cap_md) begin
      result_d   = (op_q == OP_UDIV) ? q_next : acc_next;
      carry_d    = 1'b0;
      overflow_d = 1'b0;
      divzero_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q      <= '0;
      op_q       <= OP_AND;
      result_q   <= '0;
      zero_q     <= 1'b1;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      divzero_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (accept) op_q <= alu_op_t'(bus.aluControl);
      if (cap_sc || cap_md) begin
        result_q   <= result_d;
        zero_q     <= (result_d == '0);
        negative_q <= result_d[N-1];
        carry_q    <= carry_d;
        overflow_q <= overflow_d;
        divzero_q  <= divzero_d;
      end
    end
  end

  muldiv_unit #(
    .N(N)
  ) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .load     (md_load),
    .en       (md_en),
    .div      (md_div),
    .a        (bus.a),
    .b        (bus.b),
    .acc_next (acc_next),
    .q_next   (q_next)
  );

  assign bus.ready    = (state_q != RUN);
  assign bus.done     = (state_q == DONE);
  assign bus.result   = result_q;
  assign bus.zero     = zero_q;
  assign bus.negative = negative_q;
  assign bus.carry    = carry_q;
  assign bus.overflow = overflow_q;
  assign bus.divzero  = divzero_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle at N=64 and N=16 with directed vectors.
module tb_alu_multicycle;

  typedef struct {
    string       name;
    logic [63:0] res;
    logic [4:0]  fl;      // {zero, negative, carry, overflow, divzero}
    int          edges;   // clock edges after the accepting edge until done shows
    longint      acc_cyc;
  } exp_t;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  exp_t   q64[$];
  exp_t   q16[$];
  exp_t   e64, e16;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_multicycle_if #(.N(64)) b64 ();
  alu_multicycle_if #(.N(16)) b16 ();

  alu_multicycle #(.N(64)) dut64 (.clk(clk), .reset(reset), .bus(b64));
  alu_multicycle #(.N(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic rdy(input int w);
    return (w == 64) ? b64.ready : b16.ready;
  endfunction

  // Present a request, wait (bounded) for ready, then log the expectation.
  task automatic issue(input int w, input string nm, input logic [3:0] op,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] res, input logic [4:0] fl, input int edges);
    exp_t e;
    int   guard = 0;
    @(negedge clk);
    if (w == 64) begin
      b64.start = 1'b1; b64.aluControl = op; b64.a = a; b64.b = b;
    end else begin
      b16.start = 1'b1; b16.aluControl = op; b16.a = a[15:0]; b16.b = b[15:0];
    end
    while (rdy(w) !== 1'b1 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      errors++;
      $display("FAIL %s_accept: got ready=0, expected ready=1 within 300 cycles", nm);
      return;
    end
    @(posedge clk);
    #1;
    e.name = nm; e.res = res; e.fl = fl; e.edges = edges; e.acc_cyc = cyc;
    if (w == 64) q64.push_back(e);
    else         q16.push_back(e);
  endtask

  task automatic drop();
    @(negedge clk);
    b64.start = 1'b0;
    b16.start = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && b64.done) begin
      if (q64.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done64: got done=1, expected done=0");
      end else begin
        e64 = q64.pop_front();
        chk(e64.name, {b64.result, b64.zero, b64.negative, b64.carry, b64.overflow,
                       b64.divzero}, {e64.res, e64.fl});
        chk({e64.name, "_lat"}, cyc - e64.acc_cyc, e64.edges);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b16.done) begin
      if (q16.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done16: got done=1, expected done=0");
      end else begin
        e16 = q16.pop_front();
        chk(e16.name, {48'h0, b16.result, b16.zero, b16.negative, b16.carry, b16.overflow,
                       b16.divzero}, {e16.res, e16.fl});
        chk({e16.name, "_lat"}, cyc - e16.acc_cyc, e16.edges);
      end
    end
  end

  initial begin
    int busy;
    b64.start = 1'b0; b64.aluControl = 4'h0; b64.a = '0; b64.b = '0;
    b16.start = 1'b0; b16.aluControl = 4'h0; b16.a = '0; b16.b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state64", {b64.ready, b64.done, b64.result, b64.zero, b64.negative, b64.carry,
                          b64.overflow, b64.divzero}, {2'b10, 64'h0, 5'b10000});
    chk("reset_state16", {b16.ready, b16.done, b16.result, b16.zero, b16.negative, b16.carry,
                          b16.overflow, b16.divzero}, {2'b10, 16'h0, 5'b10000});
    reset = 1'b0;

    // Back-to-back single-cycle ops with start held high.
    issue(64, "add_ffff", 4'h2, 64'hFFFF, 64'hFFFF, 64'h1FFFE, 5'b00000, 0);
    issue(64, "add_wrap", 4'h2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 5'b10100, 0);
    issue(64, "sub_neg", 4'h6, 64'h569B, 64'hB858, 64'hFFFF_FFFF_FFFF_9E43, 5'b01000, 0);
    issue(64, "sub_ovf", 4'h6, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF,
          5'b00110, 0);
    issue(64, "add_ovf", 4'h2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000,
          5'b01010, 0);
    issue(64, "or", 4'h1, 64'hF0, 64'h0F, 64'hFF, 5'b00000, 0);
    issue(64, "passb", 4'h7, 64'h1234, 64'h5, 64'h5, 5'b00000, 0);
    drop();

    // MUL with stray start pulses while busy.
    issue(64, "mul", 4'h8, 64'h967B, 64'hC8A1, 64'h75EE_BB5B, 5'b00000, 63);
    busy = 0;
    b64.start = 1'b0;
    b64.aluControl = 4'h2;
    while (busy < 200) begin
      @(negedge clk);
      if (b64.ready) break;
      busy++;
      b64.start = (busy == 5) || (busy == 30);
    end
    b64.start = 1'b0;
    chk("mul_busy_cycles", busy, 63);

    issue(64, "udiv", 4'h9, 64'h15F1C, 64'hC8A1, 64'h1, 5'b00000, 63);
    issue(64, "urem", 4'hA, 64'h15F1C, 64'hC8A1, 64'h967B, 5'b00000, 63);
    issue(64, "udiv_by0", 4'h9, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 5'b01001, 0);
    issue(64, "urem_by0", 4'hA, 64'h1234, 64'h0, 64'h1234, 5'b00001, 0);
    drop();

    // Reset 20 cycles into a MUL aborts it silently.
    @(negedge clk);
    b64.start = 1'b1; b64.aluControl = 4'h8; b64.a = 64'h967B; b64.b = 64'hC8A1;
    @(negedge clk);
    b64.start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_state", {b64.ready, b64.done, b64.result, b64.zero}, {2'b10, 64'h0, 1'b1});
    issue(64, "and", 4'h0, 64'hABC, 64'hDEF, 64'h8AC, 5'b00000, 0);
    issue(64, "illegal", 4'hF, 64'h1234, 64'h5678, 64'h0, 5'b10000, 0);
    drop();

    // Narrow instance.
    issue(16, "add16_ffff", 4'h2, 64'hFFFF, 64'hFFFF, 64'hFFFE, 5'b01100, 0);
    issue(16, "add16_wrap", 4'h2, 64'hFFFF, 64'h1, 64'h0, 5'b10100, 0);
    issue(16, "mul16", 4'h8, 64'hFFFF, 64'hFFFF, 64'h1, 5'b00000, 15);
    issue(16, "udiv16", 4'h9, 64'hC8A1, 64'h967B, 64'h1, 5'b00000, 15);
    issue(16, "urem16", 4'hA, 64'hC8A1, 64'h967B, 64'h3226, 5'b00000, 15);
    issue(16, "udiv16_by0", 4'h9, 64'h1234, 64'h0, 64'hFFFF, 5'b01001, 0);
    drop();

    for (int i = 0; i < 500 && (q64.size() != 0 || q16.size() != 0); i++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("pending64", q64.size(), 0);
    chk("pending16", q16.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
